// File: rtl/xriscv_load_wb_buffer.sv
// Load-writeback buffer: in-order tag FIFO plus one hold entry driving register-file write port B.
// Optional macro XRISCV_LOAD_WB_FWD_EN adds hold-register forwarding outputs (fwd_sel_o, fwd_data_o).
module xriscv_load_wb_buffer #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid_i,
  input  logic [ADDR_WIDTH-1:0]       req_rd_i,
  output logic                        req_ready_o,
  input  logic                        rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]       rsp_rdata_i,
  input  logic                        rsp_err_i,
  output logic                        rsp_ready_o,
  input  logic                        port_busy_i,
  output logic [ADDR_WIDTH-1:0]       waddr_b_o,
  output logic [DATA_WIDTH-1:0]       wdata_b_o,
  output logic                        we_b_o,
  input  logic [ADDR_WIDTH-1:0]       chk_addr_a_i,
  input  logic [ADDR_WIDTH-1:0]       chk_addr_b_i,
  input  logic [ADDR_WIDTH-1:0]       chk_addr_c_i,
  output logic                        hazard_o,
  output logic [$clog2(DEPTH):0]      pending_cnt_o,
  output logic                        proto_err_o
`ifdef XRISCV_LOAD_WB_FWD_EN
  ,
  output logic [2:0]                  fwd_sel_o,
  output logic [DATA_WIDTH-1:0]       fwd_data_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshakes: a request is taken when req_valid_i & req_ready_o at the rising edge;
  // a response is taken when rsp_valid_i & rsp_ready_o. Ready never depends on valid.

  logic [ADDR_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_hold_valid;
  logic [ADDR_WIDTH-1:0] r_hold_rd;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_hold_err;
  logic [CNT_W-1:0]      r_pending;
  logic                  r_proto_err;

  logic                  w_full;
  logic                  w_nonempty;
  logic                  w_drain;
  logic                  w_push;
  logic                  w_pop;
  logic [CNT_W-1:0]      w_count_nxt;
  logic                  w_hold_valid_nxt;
  logic [DEPTH-1:0]      w_entry_valid;
  logic [ADDR_WIDTH-1:0] w_chk [3];
  logic [2:0]            w_chk_nz;
  logic [2:0]            w_fifo_hit;
  logic [2:0]            w_hold_hit;
  logic [2:0]            w_fwd_sel;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_nonempty = (r_count != '0);
  // Error and x0 entries never write, so they leave the hold without waiting for the port.
  assign w_drain    = r_hold_valid & (r_hold_err | (r_hold_rd == '0) | ~port_busy_i);

  assign req_ready_o = ~w_full;
  assign rsp_ready_o = (~r_hold_valid | w_drain) & w_nonempty;

  assign w_push = req_valid_i & req_ready_o;
  assign w_pop  = rsp_valid_i & rsp_ready_o;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  assign w_hold_valid_nxt = w_pop | (r_hold_valid & ~w_drain);

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    logic [PTR_W-1:0] w_off;
    assign w_off              = PTR_W'(gi) - r_rd_ptr;
    assign w_entry_valid[gi]  = ({1'b0, w_off} < r_count);
  end

  assign w_chk[0] = chk_addr_a_i;
  assign w_chk[1] = chk_addr_b_i;
  assign w_chk[2] = chk_addr_c_i;

  always_comb begin
    w_fifo_hit = '0;
    w_hold_hit = '0;
    w_chk_nz   = '0;
    for (int k = 0; k < 3; k++) begin
      w_chk_nz[k]   = (w_chk[k] != '0);
      w_hold_hit[k] = r_hold_valid & (r_hold_rd == w_chk[k]);
      for (int i = 0; i < DEPTH; i++) begin
        if (w_entry_valid[i] && (r_mem[i] == w_chk[k])) begin
          w_fifo_hit[k] = 1'b1;
        end
      end
    end
  end

`ifdef XRISCV_LOAD_WB_FWD_EN
  // Only the hold value is final; a younger FIFO entry to the same rd still blocks.
  assign w_fwd_sel  = w_chk_nz & w_hold_hit & ~w_fifo_hit & {3{~r_hold_err}};
  assign fwd_sel_o  = w_fwd_sel;
  assign fwd_data_o = r_hold_data;
`else
  assign w_fwd_sel  = '0;
`endif

  assign hazard_o = |(w_chk_nz & (w_fifo_hit | (w_hold_hit & ~w_fwd_sel)));

  assign we_b_o        = r_hold_valid & ~r_hold_err & (r_hold_rd != '0) & ~port_busy_i;
  assign waddr_b_o     = r_hold_rd;
  assign wdata_b_o     = r_hold_data;
  assign pending_cnt_o = r_pending;
  assign proto_err_o   = r_proto_err;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= req_rd_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_hold_valid <= 1'b0;
      r_hold_rd    <= '0;
      r_hold_data  <= '0;
      r_hold_err   <= 1'b0;
      r_pending    <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_hold_rd   <= r_mem[r_rd_ptr];
        r_hold_data <= rsp_rdata_i;
        r_hold_err  <= rsp_err_i;
      end
      r_count      <= w_count_nxt;
      r_hold_valid <= w_hold_valid_nxt;
      r_pending    <= w_count_nxt + {{PTR_W{1'b0}}, w_hold_valid_nxt};
      if (rsp_valid_i && !w_nonempty && !r_hold_valid) begin
        r_proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xriscv_load_wb_buffer.sv
// Self-checking bench for xriscv_load_wb_buffer: queue-based reference model, directed cases, random traffic.
module tb_xriscv_load_wb_buffer;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          req_valid_i;
  logic [AW-1:0] req_rd_i;
  logic          req_ready_o;
  logic          rsp_valid_i;
  logic [DW-1:0] rsp_rdata_i;
  logic          rsp_err_i;
  logic          rsp_ready_o;
  logic          port_busy_i;
  logic [AW-1:0] waddr_b_o;
  logic [DW-1:0] wdata_b_o;
  logic          we_b_o;
  logic [AW-1:0] chk_addr_a_i;
  logic [AW-1:0] chk_addr_b_i;
  logic [AW-1:0] chk_addr_c_i;
  logic          hazard_o;
  logic [CW-1:0] pending_cnt_o;
  logic          proto_err_o;
`ifdef XRISCV_LOAD_WB_FWD_EN
  logic [2:0]    fwd_sel_o;
  logic [DW-1:0] fwd_data_o;
`endif

  xriscv_load_wb_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_rd_i(req_rd_i), .req_ready_o(req_ready_o),
    .rsp_valid_i(rsp_valid_i), .rsp_rdata_i(rsp_rdata_i), .rsp_err_i(rsp_err_i),
    .rsp_ready_o(rsp_ready_o), .port_busy_i(port_busy_i),
    .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o), .we_b_o(we_b_o),
    .chk_addr_a_i(chk_addr_a_i), .chk_addr_b_i(chk_addr_b_i), .chk_addr_c_i(chk_addr_c_i),
    .hazard_o(hazard_o), .pending_cnt_o(pending_cnt_o), .proto_err_o(proto_err_o)
`ifdef XRISCV_LOAD_WB_FWD_EN
    , .fwd_sel_o(fwd_sel_o), .fwd_data_o(fwd_data_o)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected test end");
    $fatal(1, "watchdog");
  end

  // reference model state
  int                   n_checks = 0;
  int                   n_fail   = 0;
  logic [AW-1:0]        fifo_q[$];
  logic                 h_v;
  logic [AW-1:0]        h_rd;
  logic [DW-1:0]        h_data;
  logic                 h_err;
  logic                 m_proto;
  logic [AW+DW-1:0]     exp_q[$];
  logic [AW-1:0]        wr_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fifo_q.delete();
    exp_q.delete();
    h_v     = 1'b0;
    h_rd    = '0;
    h_data  = '0;
    h_err   = 1'b0;
    m_proto = 1'b0;
  endtask

  // Compare every DUT output against the model's pre-edge view for the current inputs.
  task automatic model_check();
    logic          e_ready, e_drain, e_rrdy, e_we, e_hz;
    logic [2:0]    e_fs;
    logic [AW-1:0] c [3];
    bit            in_fifo, in_hold;
    c[0] = chk_addr_a_i;
    c[1] = chk_addr_b_i;
    c[2] = chk_addr_c_i;
    e_ready = (fifo_q.size() < DEPTH);
    e_drain = h_v && (h_err || h_rd == 0 || !port_busy_i);
    e_rrdy  = (!h_v || e_drain) && (fifo_q.size() > 0);
    e_we    = h_v && !h_err && h_rd != 0 && !port_busy_i;
    e_hz    = 1'b0;
    e_fs    = 3'b000;
    for (int k = 0; k < 3; k++) begin
      if (c[k] != 0) begin
        in_fifo = 0;
        foreach (fifo_q[i]) if (fifo_q[i] == c[k]) in_fifo = 1;
        in_hold = h_v && (h_rd == c[k]);
`ifdef XRISCV_LOAD_WB_FWD_EN
        if (in_hold && !h_err && !in_fifo) e_fs[k] = 1'b1;
`endif
        if (in_fifo || (in_hold && !e_fs[k])) e_hz = 1'b1;
      end
    end
    check("req_ready", req_ready_o, e_ready);
    check("rsp_ready", rsp_ready_o, e_rrdy);
    check("we_b", we_b_o, e_we);
    check("hazard", hazard_o, e_hz);
    check("pending_cnt", pending_cnt_o, fifo_q.size() + int'(h_v));
    check("proto_err", proto_err_o, m_proto);
`ifdef XRISCV_LOAD_WB_FWD_EN
    check("fwd_sel", fwd_sel_o, e_fs);
    if (h_v) check("fwd_data", fwd_data_o, h_data);
`endif
    if (we_b_o === 1'b1) begin
      wr_log.push_back(waddr_b_o);
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 1, 0);
      end else begin
        check("wr_order", {waddr_b_o, wdata_b_o}, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  endtask

  // Advance the model by one edge using the current inputs.
  task automatic model_update();
    logic ready, drain, rrdy;
    ready = (fifo_q.size() < DEPTH);
    drain = h_v && (h_err || h_rd == 0 || !port_busy_i);
    rrdy  = (!h_v || drain) && (fifo_q.size() > 0);
    if (rsp_valid_i && fifo_q.size() == 0 && !h_v) m_proto = 1'b1;
    if (rsp_valid_i && rrdy) begin
      h_rd   = fifo_q.pop_front();
      h_data = rsp_rdata_i;
      h_err  = rsp_err_i;
      h_v    = 1'b1;
      if (!h_err && h_rd != 0) exp_q.push_back({h_rd, h_data});
    end else if (drain) begin
      h_v = 1'b0;
    end
    if (req_valid_i && ready) fifo_q.push_back(req_rd_i);
  endtask

  // driver tasks
  task automatic idle();
    req_valid_i  = 1'b0;
    req_rd_i     = '0;
    rsp_valid_i  = 1'b0;
    rsp_rdata_i  = '0;
    rsp_err_i    = 1'b0;
    port_busy_i  = 1'b0;
    chk_addr_a_i = '0;
    chk_addr_b_i = '0;
    chk_addr_c_i = '0;
  endtask

  task automatic begin_cyc();
    @(negedge clk);
    idle();
  endtask

  task automatic settle();
    #1;
    model_check();
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic push(input logic [AW-1:0] rd);
    begin_cyc();
    req_valid_i = 1'b1;
    req_rd_i    = rd;
    settle();
    step();
  endtask

  task automatic idle_cycle();
    begin_cyc();
    settle();
    step();
  endtask

  logic [AW-1:0] exp_order [5];
  bit            accepted;

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // single load
    push(5);
    begin_cyc();
    rsp_valid_i = 1'b1;
    rsp_rdata_i = 32'hDEADBEEF;
    settle();
    check("single_rsp_ready", rsp_ready_o, 1);
    step();
    begin_cyc();
    settle();
    check("single_we", we_b_o, 1);
    check("single_waddr", waddr_b_o, 5);
    check("single_wdata", wdata_b_o, 32'hDEADBEEF);
    step();
    begin_cyc();
    settle();
    check("single_pending_zero", pending_cnt_o, 0);
    step();

    // fill, full push ignored, push while full with response, write order
    wr_log.delete();
    for (int r = 1; r <= 4; r++) push(AW'(r));
    begin_cyc();
    req_valid_i = 1'b1;
    req_rd_i    = 5'd5;
    settle();
    check("full_req_ready", req_ready_o, 0);
    check("full_pending", pending_cnt_o, 4);
    step();
    begin_cyc();
    req_valid_i = 1'b1;
    req_rd_i    = 5'd6;
    rsp_valid_i = 1'b1;
    rsp_rdata_i = 32'h1001;
    settle();
    check("full_rsp_ready", rsp_ready_o, 1);
    step();
    accepted = 0;
    for (int n = 0; n < 10 && !accepted; n++) begin
      begin_cyc();
      req_valid_i = 1'b1;
      req_rd_i    = 5'd6;
      settle();
      if (n == 0) check("full_pending_kept", pending_cnt_o, 4);
      accepted = req_ready_o;
      step();
    end
    check("rd6_accepted", accepted, 1);
    for (int n = 0; n < 30 && wr_log.size() < 5; n++) begin
      begin_cyc();
      if (fifo_q.size() > 0) begin
        rsp_valid_i = 1'b1;
        rsp_rdata_i = 32'h1002 + n;
      end
      settle();
      step();
    end
    exp_order[0] = 1; exp_order[1] = 2; exp_order[2] = 3; exp_order[3] = 4; exp_order[4] = 6;
    check("full_write_count", wr_log.size(), 5);
    for (int i = 0; i < 5 && i < wr_log.size(); i++) check("full_write_rd", wr_log[i], exp_order[i]);
    idle_cycle();

    // port busy holds the write
    push(7);
    push(8);
    begin_cyc();
    rsp_valid_i = 1'b1;
    rsp_rdata_i = 32'h77;
    settle();
    step();
    for (int n = 0; n < 3; n++) begin
      begin_cyc();
      port_busy_i = 1'b1;
      rsp_valid_i = 1'b1;
      rsp_rdata_i = 32'h88;
      settle();
      check("busy_we", we_b_o, 0);
      check("busy_rsp_ready", rsp_ready_o, 0);
      step();
    end
    begin_cyc();
    rsp_valid_i = 1'b1;
    rsp_rdata_i = 32'h88;
    settle();
    check("free_we", we_b_o, 1);
    check("free_waddr", waddr_b_o, 7);
    check("free_wdata", wdata_b_o, 32'h77);
    step();
    begin_cyc();
    settle();
    check("next_waddr", waddr_b_o, 8);
    step();

    // error response
    push(9);
    begin_cyc();
    chk_addr_a_i = 5'd9;
    settle();
    check("err_hazard_pending", hazard_o, 1);
    step();
    begin_cyc();
    rsp_valid_i = 1'b1;
    rsp_err_i   = 1'b1;
    rsp_rdata_i = 32'h99;
    chk_addr_a_i = 5'd9;
    settle();
    step();
    begin_cyc();
    chk_addr_a_i = 5'd9;
    settle();
    check("err_no_write", we_b_o, 0);
    step();
    begin_cyc();
    chk_addr_a_i = 5'd9;
    settle();
    check("err_hazard_clear", hazard_o, 0);
    check("err_retired", pending_cnt_o, 0);
    step();

    // hazard on rd=0 / rd=12
    push(0);
    push(12);
    begin_cyc();
    chk_addr_a_i = 5'd0;
    settle();
    check("hz_zero", hazard_o, 0);
    step();
    begin_cyc();
    chk_addr_b_i = 5'd12;
    settle();
    check("hz_twelve", hazard_o, 1);
    step();
    begin_cyc();
    rsp_valid_i = 1'b1;
    rsp_rdata_i = 32'hA0;
    settle();
    step();
    begin_cyc();
    rsp_valid_i = 1'b1;
    rsp_rdata_i = 32'hC12;
    settle();
    step();
    begin_cyc();
    chk_addr_b_i = 5'd12;
    port_busy_i  = 1'b1;
    settle();
`ifdef XRISCV_LOAD_WB_FWD_EN
    check("hz_hold_fwd", hazard_o, 0);
    check("fwd_sel_b", fwd_sel_o, 3'b010);
    check("fwd_data_val", fwd_data_o, 32'hC12);
`else
    check("hz_hold", hazard_o, 1);
`endif
    step();
    idle_cycle();
    idle_cycle();

    // protocol error
    begin_cyc();
    rsp_valid_i = 1'b1;
    settle();
    check("proto_before", proto_err_o, 0);
    step();
    for (int n = 0; n < 4; n++) begin
      begin_cyc();
      settle();
      check("proto_sticky", proto_err_o, 1);
      step();
    end

    // reset mid-operation
    push(3);
    push(4);
    push(5);
    do_reset();
    begin_cyc();
    chk_addr_a_i = 5'd3;
    chk_addr_b_i = 5'd4;
    chk_addr_c_i = 5'd5;
    settle();
    check("rst_req_ready", req_ready_o, 1);
    check("rst_we", we_b_o, 0);
    check("rst_hazard", hazard_o, 0);
    check("rst_pending", pending_cnt_o, 0);
    check("rst_proto", proto_err_o, 0);
    step();
    for (int n = 0; n < 3; n++) begin
      begin_cyc();
      settle();
      check("rst_no_write", we_b_o, 0);
      step();
    end

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      begin_cyc();
      req_valid_i  = ($urandom_range(0, 1) == 1);
      req_rd_i     = AW'($urandom_range(0, 7));
      if (fifo_q.size() > 0 || h_v) rsp_valid_i = ($urandom_range(0, 1) == 1);
      else                          rsp_valid_i = ($urandom_range(0, 49) == 0);
      rsp_rdata_i  = $urandom;
      rsp_err_i    = ($urandom_range(0, 7) == 0);
      port_busy_i  = ($urandom_range(0, 9) < 3);
      chk_addr_a_i = AW'($urandom_range(0, 7));
      chk_addr_b_i = AW'($urandom_range(0, 7));
      chk_addr_c_i = AW'($urandom_range(0, 7));
      settle();
      step();
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
